// File: rtl/ascon_fsm.sv
// Ascon-128 sequencer: drives a one-round-per-cycle permutation_xor through INIT, AD, PT and FINAL.
// Latency: 12-cycle INIT, 6 cycles per AD/PT block (acceptance cycle included), 12-cycle FINAL, then DONE.
// Backpressure: block_ready_o is high only in WAIT_AD/WAIT_PT; with block_valid_i low the FSM stalls there.
// Optional abort_i port is enabled by defining ASCON_FSM_ABORT_EN.
module ascon_fsm #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         block_valid_i,
    input  logic [63:0]  block_i,
`ifdef ASCON_FSM_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         block_ready_o,
    output logic [3:0]   round_o,
    output logic         input_select_o,
    output logic         ena_xor_up_o,
    output logic         ena_xor_down_o,
    output logic         ena_reg_state_o,
    output logic [63:0]  data_xor_up_o,
    output logic [255:0] data_xor_down_o,
    output logic         cipher_valid_o,
    output logic         tag_valid_o,
    output logic         done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_DONE
    } state_t;

    localparam logic [3:0] AD_LAST  = 4'(NB_AD_BLOCKS);
    localparam logic [3:0] PT_LAST  = 4'(NB_PT_BLOCKS);
    // Penultimate PT block carries the finalization key XOR; the last one goes straight to FINAL.
    localparam logic [3:0] PT_KEY   = 4'(NB_PT_BLOCKS - 1);
    localparam logic [3:0] RND_LAST = 4'd11;
    localparam logic [3:0] RND_DATA = 4'd6;

    state_t     state, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] ad_cnt, ad_cnt_d;
    logic [3:0] pt_cnt, pt_cnt_d;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state   <= S_IDLE;
            round_q <= 4'd0;
            ad_cnt  <= 4'd0;
            pt_cnt  <= 4'd0;
        end
`ifdef ASCON_FSM_ABORT_EN
        else if (abort_i) begin
            state   <= S_IDLE;
            round_q <= 4'd0;
            ad_cnt  <= 4'd0;
            pt_cnt  <= 4'd0;
        end
`endif
        else begin
            state   <= state_d;
            round_q <= round_d;
            ad_cnt  <= ad_cnt_d;
            pt_cnt  <= pt_cnt_d;
        end
    end

    // The bus mirrors block_i while a message is active and is quiet in IDLE.
    assign data_xor_up_o = (state == S_IDLE) ? 64'h0 : block_i;

    always_comb begin
        state_d         = state;
        round_d         = round_q;
        ad_cnt_d        = ad_cnt;
        pt_cnt_d        = pt_cnt;
        block_ready_o   = 1'b0;
        round_o         = 4'd0;
        input_select_o  = 1'b0;
        ena_xor_up_o    = 1'b0;
        ena_xor_down_o  = 1'b0;
        ena_reg_state_o = 1'b0;
        data_xor_down_o = 256'h0;
        cipher_valid_o  = 1'b0;
        tag_valid_o     = 1'b0;
        done_o          = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                tag_valid_o = (state == S_DONE);
                done_o      = (state == S_DONE);
                if (start_i) begin
                    state_d  = S_INIT;
                    round_d  = 4'd0;
                    ad_cnt_d = 4'd0;
                    pt_cnt_d = 4'd0;
                end
            end

            S_INIT: begin
                round_o         = round_q;
                ena_reg_state_o = 1'b1;
                input_select_o  = (round_q == 4'd0);
                if (round_q == RND_LAST) begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                    state_d         = S_WAIT_AD;
                    round_d         = RND_DATA;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            S_WAIT_AD: begin
                block_ready_o = 1'b1;
                round_o       = round_q;
                // Acceptance cycle doubles as round 6 of the block.
                if (block_valid_i) begin
                    ena_xor_up_o    = 1'b1;
                    ena_reg_state_o = 1'b1;
                    ad_cnt_d        = (ad_cnt == AD_LAST) ? ad_cnt : ad_cnt + 4'd1;
                    state_d         = S_AD;
                    round_d         = RND_DATA + 4'd1;
                end
            end

            S_AD: begin
                round_o         = round_q;
                ena_reg_state_o = 1'b1;
                if (round_q == RND_LAST) begin
                    round_d = RND_DATA;
                    if (ad_cnt == AD_LAST) begin
                        ena_xor_down_o  = 1'b1;
                        data_xor_down_o = (PT_LAST == 4'd1) ? {key_i, 127'h0, 1'b1} : 256'h1;
                        state_d         = S_WAIT_PT;
                    end else begin
                        state_d = S_WAIT_AD;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            S_WAIT_PT: begin
                block_ready_o = 1'b1;
                round_o       = round_q;
                if (block_valid_i) begin
                    ena_xor_up_o    = 1'b1;
                    ena_reg_state_o = 1'b1;
                    cipher_valid_o  = 1'b1;
                    pt_cnt_d        = (pt_cnt == PT_LAST) ? pt_cnt : pt_cnt + 4'd1;
                    if (pt_cnt == PT_KEY) begin
                        state_d = S_FINAL;
                        round_d = 4'd0;
                    end else begin
                        state_d = S_PT;
                        round_d = RND_DATA + 4'd1;
                    end
                end
            end

            S_PT: begin
                round_o         = round_q;
                ena_reg_state_o = 1'b1;
                if (round_q == RND_LAST) begin
                    if (pt_cnt == PT_KEY) begin
                        ena_xor_down_o  = 1'b1;
                        data_xor_down_o = {key_i, 128'h0};
                    end
                    state_d = S_WAIT_PT;
                    round_d = RND_DATA;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            S_FINAL: begin
                round_o         = round_q;
                ena_reg_state_o = 1'b1;
                ena_xor_up_o    = (round_q == 4'd0);
                if (round_q == RND_LAST) begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                    state_d         = S_DONE;
                    round_d         = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: default instance plus an NB_PT_BLOCKS=1 instance, trace model and directed corners.
module tb_ascon_fsm;

    typedef struct packed {
        logic         ready;
        logic [3:0]   round;
        logic         isel;
        logic         up;
        logic         dn_en;
        logic [255:0] dn;
        logic         reg_en;
        logic         cv;
        logic         tag;
        logic         done;
    } rec_t;

    typedef struct {
        int gap;
        int tag_t;
        int cv_n;
        int rdy_n;
    } vec_t;

    localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam int MAXT = 256;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [127:0] key_in;
    logic         valid;
    logic [63:0]  blk_in;
`ifdef ASCON_FSM_ABORT_EN
    logic         abort;
`endif

    logic         ready0, isel0, up0, dn_en0, reg0, cv0, tag0, done0;
    logic [3:0]   round0;
    logic [63:0]  upd0;
    logic [255:0] dn0;
    logic         ready1, isel1, up1, dn_en1, reg1, cv1, tag1, done1;
    logic [3:0]   round1;
    logic [63:0]  upd1;
    logic [255:0] dn1;

    always #5 clk = ~clk;

    ascon_fsm dut (
        .clock_i(clk), .resetb_i(rstn), .start_i(start), .key_i(key_in),
        .block_valid_i(valid), .block_i(blk_in),
`ifdef ASCON_FSM_ABORT_EN
        .abort_i(abort),
`endif
        .block_ready_o(ready0), .round_o(round0), .input_select_o(isel0),
        .ena_xor_up_o(up0), .ena_xor_down_o(dn_en0), .ena_reg_state_o(reg0),
        .data_xor_up_o(upd0), .data_xor_down_o(dn0), .cipher_valid_o(cv0),
        .tag_valid_o(tag0), .done_o(done0)
    );

    ascon_fsm #(.NB_AD_BLOCKS(1), .NB_PT_BLOCKS(1)) dut1 (
        .clock_i(clk), .resetb_i(rstn), .start_i(start), .key_i(key_in),
        .block_valid_i(valid), .block_i(blk_in),
`ifdef ASCON_FSM_ABORT_EN
        .abort_i(abort),
`endif
        .block_ready_o(ready1), .round_o(round1), .input_select_o(isel1),
        .ena_xor_up_o(up1), .ena_xor_down_o(dn_en1), .ena_reg_state_o(reg1),
        .data_xor_up_o(upd1), .data_xor_down_o(dn1), .cipher_valid_o(cv1),
        .tag_valid_o(tag1), .done_o(done1)
    );

    rec_t obs0, obs1;
    assign obs0 = {ready0, round0, isel0, up0, dn_en0, dn0, reg0, cv0, tag0, done0};
    assign obs1 = {ready1, round1, isel1, up1, dn_en1, dn1, reg1, cv1, tag1, done1};

    int total = 0;
    int bad   = 0;

    // Expected per-cycle trace, indexed from the first INIT cycle.
    rec_t        ex   [MAXT];
    bit          vv   [MAXT];
    bit          ss   [MAXT];
    logic [63:0] bv   [MAXT];
    int          tlen;

    task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input rec_t e, input bit v, input bit s);
        ex[tlen] = e;
        vv[tlen] = v;
        ss[tlen] = s;
        bv[tlen] = {$urandom, $urandom};
        tlen++;
    endtask

    // Schedule of a whole message: INIT, each block (waits, acceptance, remaining rounds), FINAL, DONE.
    // start_i and block_valid_i get random noise wherever they must be ignored.
    task automatic build(input int nb_ad, input int nb_pt, input int gap, input logic [127:0] k);
        rec_t e;
        int   g;
        bit   is_pt;
        int   kb;
        tlen = 0;
        for (int r = 0; r < 12; r++) begin
            e = '0; e.round = 4'(r); e.isel = (r == 0); e.reg_en = 1'b1;
            if (r == 11) begin e.dn_en = 1'b1; e.dn = {128'h0, k}; end
            push(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        for (int b = 0; b < nb_ad + nb_pt; b++) begin
            g     = (gap >= 0) ? gap : int'($urandom_range(0, 6));
            is_pt = (b >= nb_ad);
            kb    = is_pt ? b - nb_ad + 1 : b + 1;
            for (int w = 0; w < g; w++) begin
                e = '0; e.ready = 1'b1; e.round = 4'd6;
                push(e, 1'b0, ($urandom_range(0, 3) == 0));
            end
            e = '0; e.ready = 1'b1; e.round = 4'd6; e.up = 1'b1; e.reg_en = 1'b1; e.cv = is_pt;
            push(e, 1'b1, ($urandom_range(0, 3) == 0));
            if (is_pt && kb == nb_pt) begin
                for (int r = 0; r < 12; r++) begin
                    e = '0; e.round = 4'(r); e.reg_en = 1'b1; e.up = (r == 0);
                    if (r == 11) begin e.dn_en = 1'b1; e.dn = {128'h0, k}; end
                    push(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                end
            end else begin
                for (int r = 7; r < 12; r++) begin
                    e = '0; e.round = 4'(r); e.reg_en = 1'b1;
                    if (r == 11 && !is_pt && kb == nb_ad) begin
                        e.dn_en = 1'b1;
                        e.dn    = (nb_pt == 1) ? {k, 127'h0, 1'b1} : 256'h1;
                    end
                    if (r == 11 && is_pt && kb == nb_pt - 1) begin
                        e.dn_en = 1'b1; e.dn = {k, 128'h0};
                    end
                    push(e, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            e = '0; e.tag = 1'b1; e.done = 1'b1;
            push(e, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic run(input int which, input int nb_ad, input int nb_pt, input int gap,
                       input logic [127:0] k, output int tag_t, output int cv_n,
                       output int rdy_n, output int last_cv);
        rec_t        o;
        logic [63:0] u;
        tag_t = -1; cv_n = 0; rdy_n = 0; last_cv = -1;
        build(nb_ad, nb_pt, gap, k);
        key_in = k;
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; valid = 1'b0;
        #2;
        o = which ? obs1 : obs0; u = which ? upd1 : upd0;
        chk("reset_outputs", {o, u}, '0);
        @(negedge clk);
        rstn = 1'b1; start = 1'b1; valid = 1'b1; blk_in = {$urandom, $urandom};
        #2;
        o = which ? obs1 : obs0; u = which ? upd1 : upd0;
        chk("idle_outputs", {o, u}, '0);
        for (int t = 0; t < tlen; t++) begin
            @(negedge clk);
            start = ss[t]; valid = vv[t]; blk_in = bv[t];
            #2;
            o = which ? obs1 : obs0; u = which ? upd1 : upd0;
            if ({o, u} !== {ex[t], bv[t]})
                $display("trace step %0d differs", t);
            chk("trace", {o, u}, {ex[t], bv[t]});
            if (o.tag && tag_t < 0) tag_t = t;
            if (o.cv) begin cv_n++; last_cv = t; end
            if (o.ready) rdy_n++;
        end
    endtask

    initial begin
        vec_t tbl[4];
        int   tag_t, cv_n, rdy_n, last_cv;

        // Default build, NB_AD=1 / NB_PT=4: 12 INIT + 4*(g+6) + (g+1) + 12 cycles before DONE.
        tbl[0] = '{gap: 0, tag_t: 49, cv_n: 4, rdy_n: 5};
        tbl[1] = '{gap: 1, tag_t: 54, cv_n: 4, rdy_n: 10};
        tbl[2] = '{gap: 2, tag_t: 59, cv_n: 4, rdy_n: 15};
        tbl[3] = '{gap: 5, tag_t: 74, cv_n: 4, rdy_n: 30};

        rstn = 1'b0; start = 1'b0; valid = 1'b0; blk_in = '0; key_in = KEY;
`ifdef ASCON_FSM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // INIT sequence, then reset asserted mid-round 5 must clear outputs without a clock edge.
        rstn = 1'b1; start = 1'b1;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            start = 1'b0; valid = 1'b1; blk_in = 64'hA5A5_0000_0000_5A5A;
            #2;
            chk_i("init_round", int'(round0), r);
            chk_i("init_isel", int'(isel0), (r == 0) ? 1 : 0);
        end
        rstn = 1'b0;
        #1;
        chk("async_reset", {obs0, upd0}, '0);
        @(negedge clk);
        rstn = 1'b1; start = 1'b1;
        #2;
        chk("idle_after_reset", {obs0, upd0}, '0);
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
            chk_i("restart_round", int'(round0), r);
            chk_i("restart_isel", int'(isel0), (r == 0) ? 1 : 0);
            if (r == 11) begin
                chk_i("init_dn_en", int'(dn_en0), 1);
                chk("init_dn_key", {128'h0, dn0}, {128'h0, 128'h0, KEY});
            end
        end

        for (int i = 0; i < 4; i++) begin
            run(0, 1, 4, tbl[i].gap, KEY, tag_t, cv_n, rdy_n, last_cv);
            chk_i("tag_cycle", tag_t, tbl[i].tag_t);
            chk_i("cipher_pulses", cv_n, tbl[i].cv_n);
            chk_i("ready_cycles", rdy_n, tbl[i].rdy_n);
            // FINAL's 12 cycles sit between the last acceptance cycle and the first DONE cycle.
            chk_i("tag_after_last_pt", tag_t - last_cv, 13);
        end

        // DONE holds until start, then INIT begins on the next cycle.
        @(negedge clk);
        start = 1'b1;
        #2;
        chk_i("done_hold", int'(done0 & tag0), 1);
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("done_restart", {obs0.round, obs0.isel, obs0.reg_en, obs0.done},
            {4'd0, 1'b1, 1'b1, 1'b0});

        run(1, 1, 1, 0, KEY, tag_t, cv_n, rdy_n, last_cv);
        chk_i("pt1_tag_cycle", tag_t, 31);
        chk_i("pt1_cipher_pulses", cv_n, 1);
        chk_i("pt1_ready_cycles", rdy_n, 2);

        for (int i = 0; i < 4; i++) begin
            run(0, 1, 4, -1, {$urandom, $urandom, $urandom, $urandom}, tag_t, cv_n, rdy_n, last_cv);
            chk_i("rand_cipher_pulses", cv_n, 4);
            run(1, 1, 1, -1, {$urandom, $urandom, $urandom, $urandom}, tag_t, cv_n, rdy_n, last_cv);
            chk_i("rand_pt1_cipher_pulses", cv_n, 1);
        end

`ifdef ASCON_FSM_ABORT_EN
        // Abort while in PT: INIT 0..11, AD accepted at 12, AD 13..17, PT1 accepted at 18, PT at 19.
        @(negedge clk);
        rstn = 1'b0; start = 1'b0;
        @(negedge clk);
        rstn = 1'b1; start = 1'b1; valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (t == 19);
        end
        #2;
        chk_i("abort_in_pt_round", int'(round0), 7);
        @(negedge clk);
        abort = 1'b0;
        #2;
        chk("abort_idle", {obs0, upd0}, '0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("abort_restart", {obs0.round, obs0.isel}, {4'd0, 1'b1});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
